// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        IC_R       = 4'd0,
        IC_IALU    = 4'd1,
        IC_LUI     = 4'd2,
        IC_AUIPC   = 4'd3,
        IC_JAL     = 4'd4,
        IC_JALR    = 4'd5,
        IC_LOAD    = 4'd6,
        IC_STORE   = 4'd7,
        IC_BRANCH  = 4'd8,
        IC_ILLEGAL = 4'd9
    } iclass_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;
    localparam logic [1:0] DT_NONE = 2'b11;

    // Access width from funct3[1:0]; the sign bit funct3[2] is handled separately.
    function automatic logic [1:0] mem_data_type(input logic [1:0] size);
        case (size)
            2'b00:   mem_data_type = DT_BYTE;
            2'b01:   mem_data_type = DT_HALF;
            2'b10:   mem_data_type = DT_WORD;
            default: mem_data_type = DT_NONE;
        endcase
    endfunction

    // Branch resolution from the comparator flags; reserved funct3 codes never take.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic less, input logic equal);
        case (funct3)
            3'b000:  branch_taken = equal;
            3'b001:  branch_taken = !equal;
            3'b100:  branch_taken = less;
            3'b101:  branch_taken = !less;
            3'b110:  branch_taken = less;
            3'b111:  branch_taken = !less;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_insn_class_dec.sv
// rtl/multicycle_ctrl_insn_class_dec.sv - opcode classifier and ALU control decode
import ctrl_pkg::*;

module insn_class_dec (
    input  logic [31:0] i_instr,
    output iclass_t     o_class,
    output logic [3:0]  o_alu_op,
    output logic        o_opa_sel,
    output logic        o_opb_sel,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_alt;
    logic [3:0] w_alu_f3;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_alt    = i_instr[30];
    assign w_unused = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    // funct3 to ALU op, shared by R and I-ALU; the instr[30] override is applied per class.
    always_comb begin
        w_alu_f3 = ALU_ADD;
        case (w_funct3)
            3'b000: w_alu_f3 = ALU_ADD;
            3'b001: w_alu_f3 = ALU_SLL;
            3'b010: w_alu_f3 = ALU_SLT;
            3'b011: w_alu_f3 = ALU_SLTU;
            3'b100: w_alu_f3 = ALU_XOR;
            3'b101: w_alu_f3 = w_alt ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_f3 = ALU_OR;
            3'b111: w_alu_f3 = ALU_AND;
            default: w_alu_f3 = ALU_ADD;
        endcase
    end

    // Class and operand selection; PC-relative targets use PC on port A, imm on port B.
    always_comb begin
        o_class   = IC_ILLEGAL;
        o_alu_op  = ALU_ADD;
        o_opa_sel = 1'b0;
        o_opb_sel = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OPC_R: begin
                o_class   = IC_R;
                o_alu_op  = (w_funct3 == 3'b000 && w_alt) ? ALU_SUB : w_alu_f3;
                o_opb_sel = 1'b1;
            end
            OPC_IALU: begin
                o_class  = IC_IALU;
                o_alu_op = w_alu_f3;
            end
            OPC_LUI: begin
                o_class  = IC_LUI;
                o_alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                o_class   = IC_AUIPC;
                o_opa_sel = 1'b1;
            end
            OPC_JAL: begin
                o_class   = IC_JAL;
                o_opa_sel = 1'b1;
            end
            OPC_JALR:   o_class = IC_JALR;
            OPC_LOAD:   o_class = IC_LOAD;
            OPC_STORE:  o_class = IC_STORE;
            OPC_BRANCH: begin
                o_class   = IC_BRANCH;
                o_opa_sel = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle RV32I datapath
import ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_imem_req,
    output logic        o_ir_wren,
    output logic        o_pc_wren,
    output logic        o_pc_sel,
    output logic        o_rd_wren,
    output logic        o_dmem_req,
    output logic        o_mem_wren,
    output logic [1:0]  o_data_type,
    output logic        o_unsigned,
    output logic [3:0]  o_alu_op,
    output logic        o_opa_sel,
    output logic        o_opb_sel,
    output logic [1:0]  o_wb_sel,
    output logic        o_br_un,
    output logic        o_insn_vld,
    output logic        o_illegal,
    output logic        o_mem_err,
    output logic [2:0]  o_state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t       r_state;
    state_t       w_next;
    logic [CW-1:0] r_cnt;

    iclass_t    w_class;
    logic [3:0] w_dec_alu_op;
    logic       w_dec_opa_sel;
    logic       w_dec_opb_sel;
    logic       w_dec_illegal;
    logic [2:0] w_funct3;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_jump;
    logic       w_expire;

    assign w_funct3   = i_instr[14:12];
    assign w_is_load  = (w_class == IC_LOAD);
    assign w_is_store = (w_class == IC_STORE);
    assign w_is_jump  = (w_class == IC_JAL) || (w_class == IC_JALR);
    // A zero timeout never expires; otherwise the last permitted MEM cycle is CNT_LAST.
    assign w_expire   = (MEM_TIMEOUT != 0) && (r_cnt == CNT_LAST);

    insn_class_dec u_dec (
        .i_instr   (i_instr),
        .o_class   (w_class),
        .o_alu_op  (w_dec_alu_op),
        .o_opa_sel (w_dec_opa_sel),
        .o_opb_sel (w_dec_opb_sel),
        .o_illegal (w_dec_illegal)
    );

    // State register; reset wins over every state and pending ack.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // MEM wait counter: counts cycles spent in MEM, cleared whenever MEM is left.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (r_state == MEM && w_next == MEM) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Next state and per-state controls; strobes are only raised on the exit cycle of a state.
    always_comb begin
        w_next      = r_state;
        o_imem_req  = 1'b0;
        o_ir_wren   = 1'b0;
        o_pc_wren   = 1'b0;
        o_pc_sel    = 1'b0;
        o_rd_wren   = 1'b0;
        o_dmem_req  = 1'b0;
        o_mem_wren  = 1'b0;
        o_data_type = DT_NONE;
        o_unsigned  = 1'b0;
        o_alu_op    = ALU_ADD;
        o_opa_sel   = 1'b0;
        o_opb_sel   = 1'b0;
        o_wb_sel    = 2'b00;
        o_br_un     = 1'b0;
        o_insn_vld  = 1'b0;
        o_illegal   = 1'b0;
        o_mem_err   = 1'b0;
        o_state     = FETCH;
        if (i_reset) begin
            o_state = r_state;
            // ALU/writeback selects stay stable from EXEC through WB.
            if (r_state == EXEC || r_state == MEM || r_state == WB) begin
                o_alu_op  = w_dec_alu_op;
                o_opa_sel = w_dec_opa_sel;
                o_opb_sel = w_dec_opb_sel;
                o_wb_sel  = w_is_load ? WB_MEM : (w_is_jump ? WB_PC4 : WB_ALU);
            end
            case (r_state)
                FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_ack) begin
                        o_ir_wren = 1'b1;
                        w_next    = DECODE;
                    end
                end
                DECODE: begin
                    if (w_dec_illegal) begin
                        o_illegal = 1'b1;
                        o_pc_wren = 1'b1;
                        w_next    = FETCH;
                    end else begin
                        w_next = EXEC;
                    end
                end
                EXEC: begin
                    if (w_class == IC_BRANCH) begin
                        o_br_un    = w_funct3[1];
                        o_pc_wren  = 1'b1;
                        o_pc_sel   = branch_taken(w_funct3, i_br_less, i_br_equal);
                        o_insn_vld = 1'b1;
                        w_next     = FETCH;
                    end else if (w_is_load || w_is_store) begin
                        w_next = MEM;
                    end else begin
                        w_next = WB;
                    end
                end
                MEM: begin
                    o_dmem_req  = 1'b1;
                    o_mem_wren  = w_is_store;
                    o_data_type = mem_data_type(w_funct3[1:0]);
                    o_unsigned  = w_is_load && w_funct3[2];
                    if (i_dmem_ack) begin
                        if (w_is_store) begin
                            o_pc_wren  = 1'b1;
                            o_insn_vld = 1'b1;
                            w_next     = FETCH;
                        end else begin
                            w_next = WB;
                        end
                    end else if (w_expire) begin
                        o_mem_err = 1'b1;
                        o_pc_wren = 1'b1;
                        w_next    = FETCH;
                    end
                end
                WB: begin
                    o_rd_wren  = 1'b1;
                    o_pc_wren  = 1'b1;
                    o_pc_sel   = w_is_jump;
                    o_insn_vld = 1'b1;
                    w_next     = FETCH;
                end
                default: w_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instr;
    logic        i_imem_ack, i_dmem_ack, i_br_less, i_br_equal;
    logic        o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_rd_wren;
    logic        o_dmem_req, o_mem_wren, o_unsigned, o_opa_sel, o_opb_sel;
    logic        o_br_un, o_insn_vld, o_illegal, o_mem_err;
    logic [1:0]  o_data_type, o_wb_sel;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_state;

    int n_run  = 0;
    int n_fail = 0;
    int n_err  = 0;

    localparam logic [31:0] ST_F = 32'd0, ST_D = 32'd1, ST_E = 32'd2, ST_M = 32'd3, ST_W = 32'd4;

    always #5 i_clk = ~i_clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr),
        .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack),
        .i_br_less(i_br_less), .i_br_equal(i_br_equal),
        .o_imem_req(o_imem_req), .o_ir_wren(o_ir_wren), .o_pc_wren(o_pc_wren),
        .o_pc_sel(o_pc_sel), .o_rd_wren(o_rd_wren), .o_dmem_req(o_dmem_req),
        .o_mem_wren(o_mem_wren), .o_data_type(o_data_type), .o_unsigned(o_unsigned),
        .o_alu_op(o_alu_op), .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel),
        .o_wb_sel(o_wb_sel), .o_br_un(o_br_un), .o_insn_vld(o_insn_vld),
        .o_illegal(o_illegal), .o_mem_err(o_mem_err), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let inputs be changed one time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // FETCH with an immediate ack, leaving the controller in DECODE.
    task automatic do_fetch(input logic [31:0] ins);
        i_instr    = ins;
        i_imem_ack = 1'b1;
        #1;
        chk("fetch_state", 32'(o_state), ST_F);
        chk("fetch_ir_wren", 32'(o_ir_wren), 32'd1);
        tick();
        i_imem_ack = 1'b0;
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_instr = 32'h0; i_imem_ack = 1'b1; i_dmem_ack = 1'b1;
        i_br_less = 1'b0; i_br_equal = 1'b0;
        tick(); tick();
        #1;
        chk("rst_state", 32'(o_state), ST_F);
        chk("rst_imem_req", 32'(o_imem_req), 32'd0);
        chk("rst_ir_wren", 32'(o_ir_wren), 32'd0);
        chk("rst_data_type", 32'(o_data_type), 32'd3);
        i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("rel_imem_req", 32'(o_imem_req), 32'd1);

        // ADD x3,x1,x2 with one fetch wait cycle first
        i_instr = 32'h002081B3;
        chk("add_wait_ir_wren", 32'(o_ir_wren), 32'd0);
        tick();
        chk("add_wait_state", 32'(o_state), ST_F);
        do_fetch(32'h002081B3);
        chk("add_d_state", 32'(o_state), ST_D);
        chk("add_d_illegal", 32'(o_illegal), 32'd0);
        tick(); #1;
        chk("add_e_state", 32'(o_state), ST_E);
        chk("add_e_pc_wren", 32'(o_pc_wren), 32'd0);
        tick(); #1;
        chk("add_w_state", 32'(o_state), ST_W);
        chk("add_w_rd_wren", 32'(o_rd_wren), 32'd1);
        chk("add_w_alu_op", 32'(o_alu_op), 32'd0);
        chk("add_w_opb_sel", 32'(o_opb_sel), 32'd1);
        chk("add_w_wb_sel", 32'(o_wb_sel), 32'd1);
        chk("add_w_pc_wren", 32'(o_pc_wren), 32'd1);
        chk("add_w_pc_sel", 32'(o_pc_sel), 32'd0);
        chk("add_w_insn_vld", 32'(o_insn_vld), 32'd1);
        tick(); #1;
        chk("add_done_state", 32'(o_state), ST_F);
        chk("add_done_rd_wren", 32'(o_rd_wren), 32'd0);

        // LW x5,8(x0): ack on the 4th MEM cycle
        do_fetch(32'h00802283);
        tick(); #1;
        chk("lw_e_state", 32'(o_state), ST_E);
        tick();
        for (int i = 0; i < 4; i++) begin
            i_dmem_ack = (i == 3);
            #1;
            chk("lw_m_state", 32'(o_state), ST_M);
            chk("lw_m_dmem_req", 32'(o_dmem_req), 32'd1);
            chk("lw_m_mem_wren", 32'(o_mem_wren), 32'd0);
            chk("lw_m_data_type", 32'(o_data_type), 32'd0);
            chk("lw_m_rd_wren", 32'(o_rd_wren), 32'd0);
            tick();
        end
        i_dmem_ack = 1'b0;
        #1;
        chk("lw_w_state", 32'(o_state), ST_W);
        chk("lw_w_wb_sel", 32'(o_wb_sel), 32'd0);
        chk("lw_w_rd_wren", 32'(o_rd_wren), 32'd1);
        chk("lw_w_dmem_req", 32'(o_dmem_req), 32'd0);
        tick(); #1;
        chk("lw_done_state", 32'(o_state), ST_F);

        // BNE not equal -> taken
        do_fetch(32'hFE209EE3);
        tick();
        i_br_equal = 1'b0;
        #1;
        chk("bne_e_state", 32'(o_state), ST_E);
        chk("bne_e_pc_wren", 32'(o_pc_wren), 32'd1);
        chk("bne_e_pc_sel", 32'(o_pc_sel), 32'd1);
        chk("bne_e_br_un", 32'(o_br_un), 32'd0);
        chk("bne_e_opa_sel", 32'(o_opa_sel), 32'd1);
        chk("bne_e_insn_vld", 32'(o_insn_vld), 32'd1);
        tick(); #1;
        chk("bne_done_state", 32'(o_state), ST_F);

        // BNE equal -> not taken
        do_fetch(32'hFE209EE3);
        tick();
        i_br_equal = 1'b1;
        #1;
        chk("bne2_e_pc_sel", 32'(o_pc_sel), 32'd0);
        chk("bne2_e_pc_wren", 32'(o_pc_wren), 32'd1);
        tick();
        i_br_equal = 1'b0;

        // BLTU with less -> taken, unsigned compare
        do_fetch(32'h0020E063);
        tick();
        i_br_less = 1'b1;
        #1;
        chk("bltu_e_br_un", 32'(o_br_un), 32'd1);
        chk("bltu_e_pc_sel", 32'(o_pc_sel), 32'd1);
        tick();
        i_br_less = 1'b0;
        #1;
        chk("bltu_done_state", 32'(o_state), ST_F);

        // JAL x1,8 -> writeback PC+4, PC from ALU
        do_fetch(32'h008000EF);
        tick(); #1;
        chk("jal_e_opa_sel", 32'(o_opa_sel), 32'd1);
        tick(); #1;
        chk("jal_w_state", 32'(o_state), ST_W);
        chk("jal_w_wb_sel", 32'(o_wb_sel), 32'd2);
        chk("jal_w_pc_sel", 32'(o_pc_sel), 32'd1);
        tick(); #1;

        // Illegal opcode 0x00000000
        do_fetch(32'h00000000);
        chk("ill_d_state", 32'(o_state), ST_D);
        chk("ill_d_illegal", 32'(o_illegal), 32'd1);
        chk("ill_d_pc_wren", 32'(o_pc_wren), 32'd1);
        chk("ill_d_pc_sel", 32'(o_pc_sel), 32'd0);
        chk("ill_d_rd_wren", 32'(o_rd_wren), 32'd0);
        chk("ill_d_insn_vld", 32'(o_insn_vld), 32'd0);
        tick(); #1;
        chk("ill_done_state", 32'(o_state), ST_F);
        chk("ill_done_illegal", 32'(o_illegal), 32'd0);

        // SB x2,0(x1) with no ack: 16 MEM cycles, error on the last
        do_fetch(32'h00208023);
        tick(); tick();
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("sb_m_state", 32'(o_state), ST_M);
            chk("sb_m_data_type", 32'(o_data_type), 32'd2);
            chk("sb_m_mem_wren", 32'(o_mem_wren), 32'd1);
            chk("sb_m_mem_err", 32'(o_mem_err), (i == 15) ? 32'd1 : 32'd0);
            chk("sb_m_rd_wren", 32'(o_rd_wren), 32'd0);
            if (o_mem_err) n_err++;
            tick();
        end
        #1;
        chk("sb_err_count", 32'(n_err), 32'd1);
        chk("sb_done_state", 32'(o_state), ST_F);
        chk("sb_done_mem_err", 32'(o_mem_err), 32'd0);

        // SB with ack on the 16th MEM cycle: success, no error
        do_fetch(32'h00208023);
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            i_dmem_ack = (i == 15);
            #1;
            chk("sb2_m_state", 32'(o_state), ST_M);
            chk("sb2_m_mem_err", 32'(o_mem_err), 32'd0);
            chk("sb2_m_insn_vld", 32'(o_insn_vld), (i == 15) ? 32'd1 : 32'd0);
            tick();
        end
        i_dmem_ack = 1'b0;
        #1;
        chk("sb2_done_state", 32'(o_state), ST_F);

        // Reset asserted while in MEM with a request outstanding
        do_fetch(32'h00802283);
        tick(); tick();
        #1;
        chk("rstm_pre_dmem_req", 32'(o_dmem_req), 32'd1);
        i_reset    = 1'b0;
        i_dmem_ack = 1'b1;
        tick(); #1;
        chk("rstm_state", 32'(o_state), ST_F);
        chk("rstm_dmem_req", 32'(o_dmem_req), 32'd0);
        chk("rstm_data_type", 32'(o_data_type), 32'd3);
        chk("rstm_pc_wren", 32'(o_pc_wren), 32'd0);
        chk("rstm_rd_wren", 32'(o_rd_wren), 32'd0);
        chk("rstm_imem_req", 32'(o_imem_req), 32'd0);
        i_dmem_ack = 1'b0;
        i_reset    = 1'b1;
        #1;
        chk("rstm_rel_imem_req", 32'(o_imem_req), 32'd1);
        chk("rstm_rel_state", 32'(o_state), ST_F);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Sequencing controller for the multicycle variant of the RV32I core. A state machine steps the shared datapath (PC, IR, regfile, ALU, branch comparator, LSU) through FETCH/DECODE/EXEC/MEM/WB, with req/ack handshakes to instruction and data memory. It drives the same control signals and encodings as the single-cycle decoder, but holds them valid per state and qualifies write enables to exactly one cycle. It also flags illegal opcodes and data-memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for i_dmem_ack; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-low reset
i_instr  in  32  IR contents, valid from DECODE onward
i_imem_ack  in  1  instruction fetch complete; IR captures this cycle
i_dmem_ack  in  1  data access complete
i_br_less  in  1  comparator rs1<rs2 (signedness per o_br_un)
i_br_equal  in  1  comparator rs1==rs2
o_imem_req  out  1  fetch request
o_ir_wren  out  1  IR load strobe
o_pc_wren  out  1  PC update strobe
o_pc_sel  out  1  0=PC+4, 1=ALU result
o_rd_wren  out  1  regfile write strobe
o_dmem_req  out  1  data memory request
o_mem_wren  out  1  1=store, 0=load (valid with o_dmem_req)
o_data_type  out  2  00 word, 01 half, 10 byte, 11 none
o_unsigned  out  1  zero-extend load
o_alu_op  out  4  ALU operation
o_opa_sel  out  1  0=rs1, 1=PC
o_opb_sel  out  1  0=imm, 1=rs2
o_wb_sel  out  2  00 mem, 01 ALU, 10 PC+4
o_br_un  out  1  unsigned compare
o_insn_vld  out  1  one-cycle retire pulse
o_illegal  out  1  one-cycle illegal-opcode pulse
o_mem_err  out  1  one-cycle dmem-timeout pulse
o_state  out  3  current state, for debug

Behaviour:
- Reset: any edge with i_reset=0 forces state FETCH, clears the timeout counter and drives every output to 0, except o_data_type=11 and o_state=FETCH. It overrides any state; outstanding acks are ignored. In the first cycle after release, o_imem_req=1.
- FETCH: o_imem_req=1 until i_imem_ack. In the ack cycle, o_ir_wren=1 and next state is DECODE. No imem timeout.
- DECODE (1 cycle): classify the opcode.
  - Illegal opcode (anything other than R, I-ALU, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH): o_illegal=1, o_pc_wren=1, o_pc_sel=0, then FETCH. No rd write, no o_insn_vld.
  - Otherwise next state is EXEC.
- EXEC (1 cycle): ALU controls valid.
  - R: alu_op from funct3 and instr[30].
  - I-ALU: alu_op from funct3; instr[30] used only for SRAI.
  - LOAD/STORE/JALR: ADD, with imm.
  - LUI: PASSB.
  - AUIPC/JAL/BRANCH: opa_sel=1 (PC), imm.
  - BRANCH: o_br_un=funct3[1]. taken = BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less. Asserts o_pc_wren=1, o_pc_sel=taken, o_insn_vld=1, then FETCH.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: o_dmem_req=1, o_mem_wren=store. o_data_type from funct3 (000 byte, 001 half, 010 word); o_unsigned=funct3[2] for loads only. ALU controls are held.
  - On ack: load goes to WB. Store asserts o_pc_wren=1, o_pc_sel=0, o_insn_vld=1, then FETCH.
  - Counter increments each MEM cycle. When it reaches MEM_TIMEOUT without ack: o_mem_err=1, o_pc_wren=1, o_pc_sel=0, no rd write, then FETCH.
  - Ack in the same cycle the counter expires counts as success.
- WB (1 cycle): EXEC controls are held. o_rd_wren=1, o_pc_wren=1, o_insn_vld=1, then FETCH.
  - wb_sel: 00 for load, 10 for JAL/JALR, 01 otherwise.
  - o_pc_sel=1 for JAL/JALR, else 0.
- Latency with zero-wait acks:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Illegal: 2 cycles.
- Strobes (o_ir_wren, o_pc_wren, o_rd_wren, o_insn_vld, o_illegal, o_mem_err) never assert for more than 1 cycle per instruction.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB
  - alu_op constants: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1111
  - opcode constants
  - wb_sel and data_type constants
- One combinational sub-module, insn_class_dec: instr in; instruction class, alu_op, opa_sel/opb_sel and illegal flag out.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), acks immediate -> states F,D,E,W. In W: rd_wren=1, alu_op=0000, opb_sel=1, wb_sel=01, pc_wren=1, pc_sel=0, insn_vld=1. Total 4 cycles.
- LW x5,8(x0) (0x00802283), dmem_ack 3 cycles after entering MEM -> dmem_req held for 4 cycles, mem_wren=0, data_type=00. Then WB with wb_sel=00, rd_wren=1.
- BNE x1,x2,-4 (0xFE209EE3):
  - br_equal=0 -> in EXEC pc_wren=1, pc_sel=1, br_un=0, opa_sel=1, then FETCH.
  - Repeat with br_equal=1 -> pc_sel=0.
  - BLTU (0x0020E063) -> br_un=1.
- Instruction 0x00000000 -> o_illegal pulses in DECODE, pc_wren=1, pc_sel=0, rd_wren never asserts, next state FETCH.
- SB x2,0(x1) (0x00208023) with dmem_ack held low, MEM_TIMEOUT=16:
  - Exactly 16 MEM cycles with data_type=10, mem_wren=1.
  - mem_err pulses once, then FETCH.
  - Variant with ack on cycle 16 -> no mem_err.
- Reset taken in MEM with dmem_req=1 -> next cycle state FETCH, all strobes 0, data_type=11. First cycle after release: imem_req=1.
